pattern_scan_ctrl: RTL
======================

Name: pattern_scan_ctrl

Overview:
- Frame-level controller and serializer for a bit-serial dual-pattern detector (patterns 1011 = class A, 0101 = class B).
- Accepts a frame of parallel words over a valid/ready handshake and shifts each word MSB-first into an embedded overlapping Moore detector.
- Counts A/B hits per frame and reports completion with a one-cycle done pulse.
- Sits between a word-oriented producer and status/interrupt logic.

Parameters:
- W, 8, data word width in bits (>=2)
- CNT_W, 8, width of each hit counter (>=2)
- LEN_W, 8, width of frame_len

Ports:
- ck  in  1  clock, all state updates on rising edge
- rs_n  in  1  asynchronous active-low reset
- start  in  1  begin frame; sampled only in IDLE
- frame_len  in  LEN_W  words in frame; sampled with start
- in_valid  in  1  producer word valid
- in_data  in  W  producer word
- in_ready  out  1  controller can accept word (high only in LOAD)
- busy  out  1  high in every state except IDLE
- ser_bit  out  1  bit currently fed to detector (valid when ser_en=1)
- ser_en  out  1  high during SHIFT cycles
- hit_a  out  1  one-cycle pulse: 1011 just completed
- hit_b  out  1  one-cycle pulse: 0101 just completed
- cnt_a  out  CNT_W  class A hits this frame, saturating
- cnt_b  out  CNT_W  class B hits this frame, saturating
- done  out  1  one-cycle pulse at frame end

Behaviour:
- Reset (rs_n=0, asynchronous): FSM=IDLE, detector=START, all outputs 0, counters 0, word/bit counters 0. Reset mid-frame aborts the frame with no done pulse.
- FSM states: IDLE, LOAD, SHIFT, FLUSH, DONE.
- IDLE:
  - start=1 latches frame_len, clears cnt_a/cnt_b and detector to START.
  - frame_len=0 goes to DONE; otherwise goes to LOAD.
  - start is ignored in all other states.
- LOAD:
  - in_ready=1; each cycle in_valid=0 is a stall.
  - Stalls do not advance the detector, so detector state is preserved across word boundaries and stalls.
  - in_valid&in_ready captures in_data into the shift register, sets bit index to W-1, and goes to SHIFT.
- SHIFT:
  - ser_en=1, ser_bit=shreg[MSB]; the detector advances one bit per cycle and the register shifts left.
  - After W cycles: go to LOAD if words remain, else FLUSH.
- FLUSH: one cycle so the hit caused by the final bit is registered and counted. Then go to DONE.
- DONE: done=1 for one cycle, then IDLE. cnt_a/cnt_b hold until the next accepted start.
- Detector:
  - Moore, overlapping; states START,S1,S10,S101,S1011,S0,S01,S010,S0101.
  - From a complete state it continues on the longest matching suffix (e.g. 0101 followed by 1 goes to S1011, which is a class-A hit).
  - hit_a=1 exactly in cycles where detector state==S1011; hit_b likewise for S0101. The pulse appears the cycle after the completing bit's SHIFT cycle.
- Counters:
  - Increment when the corresponding hit is high.
  - Saturate at 2^CNT_W-1 with no wrap.
  - Both may increment in the same cycle only if the states differ, which cannot occur; A and B are mutually exclusive.
- Latency: per word 1 handshake cycle (minimum) + W shift cycles; frame end adds FLUSH + DONE = 2 cycles.
- Throughput: one word per W+1 cycles with in_valid held high.

Test Plan:
- Reset/single word: reset, start with frame_len=1, word 8'b1011_0101.
  - Required: hit_a pulses once (after bit 4) and hit_b once (after bit 8).
  - done pulses one cycle after FLUSH; cnt_a=1, cnt_b=1.
  - ser_en high for exactly 8 cycles.
- Overlap: frame_len=1, word 8'b0101_1011.
  - Required: hit_b after bit 4, hit_a after bit 5 and bit 8; final cnt_a=2, cnt_b=1.
- Cross-word with stall: frame_len=2, words 8'h01 then 8'h60, in_valid low 3 cycles between words.
  - Required: detector state kept across the stall; cnt_b=1 (bits 7–10), cnt_a=1 (bits 8–11).
  - in_ready high throughout the stall.
- Empty frame and ignored start: frame_len=0.
  - Required: busy high 1 cycle, done pulse, counters 0, in_ready never high.
  - A start pulsed during SHIFT of a normal frame has no effect.
- Saturation: CNT_W=2, frame of 4 words 8'hBB (bits 10111011 repeated).
  - Required: cnt_a stops at 3 with no wrap; cnt_b=0.
- Reset mid-frame: assert rs_n=0 during SHIFT of word 1 of 3.
  - Required: all outputs 0 immediately, no done pulse, FSM=IDLE.
  - The next start runs a clean frame from detector START.

Source files
------------

// File: rtl/pattern_scan_ctrl.sv
// pattern_scan_ctrl: frame controller that serializes words MSB-first into an
// overlapping Moore detector for 1011 (class A) and 0101 (class B), counting hits.
`default_nettype none

module pattern_scan_ctrl #(
  parameter int W     = 8,
  parameter int CNT_W = 8,
  parameter int LEN_W = 8
) (
  input  logic             ck,
  input  logic             rs_n,
  input  logic             start,
  input  logic [LEN_W-1:0] frame_len,
  input  logic             in_valid,
  input  logic [W-1:0]     in_data,
  output logic             in_ready,
  output logic             busy,
  output logic             ser_bit,
  output logic             ser_en,
  output logic             hit_a,
  output logic             hit_b,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b,
  output logic             done
);

  localparam int BI_W = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    D_START = 4'd0,
    D_S1    = 4'd1,
    D_S10   = 4'd2,
    D_S101  = 4'd3,
    D_S1011 = 4'd4,
    D_S0    = 4'd5,
    D_S01   = 4'd6,
    D_S010  = 4'd7,
    D_S0101 = 4'd8
  } det_t;

  state_t           state, state_n;
  det_t             det, det_n;
  logic [W-1:0]     shreg, shreg_n;
  logic [BI_W-1:0]  bit_idx, bit_idx_n;
  logic [LEN_W-1:0] words_left, words_left_n;
  logic             adv, adv_n;
  logic [CNT_W-1:0] cnt_a_r, cnt_a_n, cnt_b_r, cnt_b_n;

  // Each state is the longest suffix of the bit history that is a prefix of
  // either pattern, so a completed match keeps its overlap.
  function automatic det_t det_step(input det_t cur, input logic b);
    det_t nx;
    nx = D_START;
    case (cur)
      D_START: nx = b ? D_S1    : D_S0;
      D_S1:    nx = b ? D_S1    : D_S10;
      D_S10:   nx = b ? D_S101  : D_S0;
      D_S101:  nx = b ? D_S1011 : D_S010;
      D_S1011: nx = b ? D_S1    : D_S10;
      D_S0:    nx = b ? D_S01   : D_S0;
      D_S01:   nx = b ? D_S1    : D_S010;
      D_S010:  nx = b ? D_S0101 : D_S0;
      D_S0101: nx = b ? D_S1011 : D_S010;
      default: nx = D_START;
    endcase
    return nx;
  endfunction

  always_ff @(posedge ck or negedge rs_n) begin
    if (!rs_n) begin
      state      <= ST_IDLE;
      det        <= D_START;
      shreg      <= '0;
      bit_idx    <= '0;
      words_left <= '0;
      adv        <= 1'b0;
      cnt_a_r    <= '0;
      cnt_b_r    <= '0;
    end else begin
      state      <= state_n;
      det        <= det_n;
      shreg      <= shreg_n;
      bit_idx    <= bit_idx_n;
      words_left <= words_left_n;
      adv        <= adv_n;
      cnt_a_r    <= cnt_a_n;
      cnt_b_r    <= cnt_b_n;
    end
  end

  always_comb begin
    state_n      = state;
    det_n        = det;
    shreg_n      = shreg;
    bit_idx_n    = bit_idx;
    words_left_n = words_left;
    // A hit is reported only in the cycle right after the detector moved,
    // so a match parked across a stall or frame end is counted once.
    adv_n        = (state == ST_SHIFT);
    cnt_a_n      = (hit_a && cnt_a_r != {CNT_W{1'b1}}) ? cnt_a_r + CNT_W'(1) : cnt_a_r;
    cnt_b_n      = (hit_b && cnt_b_r != {CNT_W{1'b1}}) ? cnt_b_r + CNT_W'(1) : cnt_b_r;

    case (state)
      ST_IDLE: begin
        if (start) begin
          words_left_n = frame_len;
          cnt_a_n      = '0;
          cnt_b_n      = '0;
          det_n        = D_START;
          state_n      = (frame_len == '0) ? ST_DONE : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (in_valid) begin
          shreg_n      = in_data;
          bit_idx_n    = BI_W'(W - 1);
          words_left_n = words_left - LEN_W'(1);
          state_n      = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        det_n     = det_step(det, shreg[W-1]);
        shreg_n   = shreg << 1;
        bit_idx_n = bit_idx - BI_W'(1);
        if (bit_idx == '0) begin
          state_n = (words_left == '0) ? ST_FLUSH : ST_LOAD;
        end
      end
      ST_FLUSH: state_n = ST_DONE;
      ST_DONE:  state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  assign in_ready = (state == ST_LOAD);
  assign busy     = (state != ST_IDLE);
  assign ser_en   = (state == ST_SHIFT);
  assign ser_bit  = ser_en & shreg[W-1];
  assign hit_a    = adv & (det == D_S1011);
  assign hit_b    = adv & (det == D_S0101);
  assign done     = (state == ST_DONE);
  assign cnt_a    = cnt_a_r;
  assign cnt_b    = cnt_b_r;

endmodule

`default_nettype wire
